sync_fifo_ctrl: RTL and testbench
=================================

# sync_fifo_ctrl

Single-clock parametrised FIFO: storage array plus full control logic (read/write pointers, occupancy count, full/empty and programmable almost-full/almost-empty flags, sticky overflow/underflow errors). Selectable read mode: show-ahead (combinational head-of-queue) or registered (1-cycle read latency). Used for intra-domain buffering, e.g. between the register/command path and the UART TX path, where no clock-domain crossing is needed.

## Interface
- WIDTH, 8, data word width
- ADDR_W, 3, address bits; depth = 2**ADDR_W
- AF_LVL, 6, ALMOST_FULL asserted when COUNT >= AF_LVL
- AE_LVL, 2, ALMOST_EMPTY asserted when COUNT <= AE_LVL
- REG_OUT, 1, 0 = show-ahead read, 1 = registered read

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-low reset
- WR_EN  in  1  write request
- WR_DATA  in  WIDTH  write data
- RD_EN  in  1  read request
- CLR_ERR  in  1  clears OVERFLOW/UNDERFLOW
- RD_DATA  out  WIDTH  read data
- RD_VALID  out  1  RD_DATA qualifier
- FULL  out  1  COUNT == 2**ADDR_W
- EMPTY  out  1  COUNT == 0
- ALMOST_FULL  out  1  COUNT >= AF_LVL
- ALMOST_EMPTY  out  1  COUNT <= AE_LVL
- COUNT  out  ADDR_W+1  current occupancy
- OVERFLOW  out  1  sticky: write attempted while FULL
- UNDERFLOW  out  1  sticky: read attempted while EMPTY

## Operation
- Pointers WR_PTR/RD_PTR are ADDR_W+1 bits; low ADDR_W bits address memory; natural wrap modulo 2**(ADDR_W+1).
- Write accepted iff WR_EN && !FULL (FULL sampled before the edge); writes mem[WR_PTR], WR_PTR+1.
- Read accepted iff RD_EN && !EMPTY; RD_PTR+1.
- COUNT: +1 write only, -1 read only, unchanged when both or neither accepted. When FULL, a simultaneous write is rejected even if a read is accepted; when EMPTY, a simultaneous read is rejected even if a write is accepted.
- Rejected write sets OVERFLOW; rejected read sets UNDERFLOW. Both hold until CLR_ERR; set wins over CLR_ERR in the same cycle. Rejected accesses change no other state.
- REG_OUT=0: RD_DATA = mem[RD_PTR] combinationally; RD_VALID = !EMPTY; RD_EN acknowledges the displayed word.
- REG_OUT=1: on accepted read, RD_DATA <= mem[RD_PTR]; RD_VALID = 1 for the following cycle only; RD_DATA holds its last value otherwise.
- All flags decoded from registered COUNT: no combinational path from WR_EN/RD_EN to any flag.
- Reset: pointers, COUNT, OVERFLOW, UNDERFLOW = 0; EMPTY = 1; ALMOST_EMPTY = 1; FULL, ALMOST_FULL, RD_VALID = 0; RD_DATA = 0 (REG_OUT=1). Memory contents not reset. Reset mid-operation discards all queued data.

## Timing
- Write-to-flag: flags and COUNT update on the edge that accepts the write.
- Write-to-read: a word written at edge N is readable from edge N onward (EMPTY falls after edge N); with REG_OUT=1, a read accepted at edge N+1 yields RD_VALID/RD_DATA after edge N+1.
- Sustained throughput: one write and one read per cycle when 0 < COUNT < depth.
- Parameter legality: 0 <= AE_LVL < AF_LVL <= 2**ADDR_W.

## Structure
- Shared package/header: default WIDTH/ADDR_W constants and the read-mode encodings (SHOW_AHEAD=0, REGISTERED=1).
- One sub-module, fifo_mem_array: 2**ADDR_W x WIDTH array, synchronous write with enable, asynchronous read by address. The controller instantiates it and owns pointers, count, flags and the optional output register.

## Test plan
- Reset then idle: EMPTY=1, ALMOST_EMPTY=1, COUNT=0, all other outputs 0.
- Write 0x01..0x08 (defaults): COUNT 1..8; ALMOST_EMPTY falls at COUNT=3; ALMOST_FULL rises at COUNT=6; FULL at 8; 9th write 0xFF rejected -> OVERFLOW=1, COUNT stays 8.
- Drain all with REG_OUT=1: RD_DATA 0x01..0x08 in order, each with RD_VALID one cycle after RD_EN; extra read -> UNDERFLOW=1, RD_VALID=0.
- Continuous simultaneous write/read at COUNT=4 for 20 cycles: COUNT constant 4, data in order across pointer wrap.
- FULL with WR_EN and RD_EN together: read accepted, write rejected, OVERFLOW=1, COUNT=7; CLR_ERR next cycle -> OVERFLOW=0.
- REG_OUT=0: after one write of 0xA5, RD_DATA=0xA5 and RD_VALID=1 with no RD_EN; assert RST mid-stream -> EMPTY=1, COUNT=0 immediately.

Source files
------------

// File: rtl/sync_fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl_pkg
// Shared constants for the single-clock FIFO controller: default geometry,
// default almost-full/almost-empty thresholds and the read-mode encodings.
// -----------------------------------------------------------------------------
package sync_fifo_ctrl_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_AF_LVL = 6;
  localparam int DEF_AE_LVL = 2;

  // Read-port behaviour: SHOW_AHEAD presents the head word combinationally,
  // REGISTERED delivers the popped word one cycle after the accepted read.
  typedef enum logic {
    SHOW_AHEAD = 1'b0,
    REGISTERED = 1'b1
  } rd_mode_e;

endpackage : sync_fifo_ctrl_pkg

// File: rtl/sync_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl_if
// Bundles the FIFO push/pop handshake and status signals.
//   master : user side (drives wr_en/wr_data/rd_en/clr_err, observes status)
//   slave  : FIFO side (observes requests, drives data and status)
// Signals: wr_en, wr_data, rd_en, clr_err, rd_data, rd_valid, full, empty,
//          almost_full, almost_empty, count, overflow, underflow.
// -----------------------------------------------------------------------------
interface sync_fifo_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_en;
  logic              clr_err;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface : sync_fifo_ctrl_if

// File: rtl/sync_fifo_ctrl_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem_array
// 2**ADDR_W x WIDTH storage: synchronous write with enable, asynchronous read.
// Contents are deliberately not reset.
// Ports: clk_i, we_i, waddr_i, wdata_i, raddr_i, rdata_o.
// -----------------------------------------------------------------------------
module fifo_mem_array #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : fifo_mem_array

// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
// Single-clock FIFO controller: pointers, occupancy, status flags, sticky
// overflow/underflow and either a show-ahead or a registered read port.
// Ports:
//   clk_i  : clock, all state changes on rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : sync_fifo_ctrl_if.slave (requests in, data/status out)
// -----------------------------------------------------------------------------
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int       WIDTH   = DEF_WIDTH,
  parameter int       ADDR_W  = DEF_ADDR_W,
  parameter int       AF_LVL  = DEF_AF_LVL,
  parameter int       AE_LVL  = DEF_AE_LVL,
  parameter rd_mode_e REG_OUT = REGISTERED
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  sync_fifo_ctrl_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LVL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LVL);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]  count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             full, empty;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] mem_rdata;

  // Flags come from registered count only, so no request input reaches them.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // A full FIFO refuses writes even when a read frees a slot in the same
  // cycle; likewise an empty FIFO refuses reads alongside a write.
  assign wr_ok = bus.wr_en && !full;
  assign rd_ok = bus.rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + ONE_C;
    if (rd_ok) rd_ptr_d = rd_ptr_q + ONE_C;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    // New error events take priority over a clear in the same cycle.
    overflow_d  = (bus.wr_en && full)  || (overflow_q  && !bus.clr_err);
    underflow_d = (bus.rd_en && empty) || (underflow_q && !bus.clr_err);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem_array #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (mem_rdata)
  );

  generate
    if (REG_OUT == REGISTERED) begin : g_reg
      logic [WIDTH-1:0] rd_data_q, rd_data_d;
      logic             rd_valid_q;

      // Output word holds its last value between accepted reads.
      always_comb rd_data_d = rd_ok ? mem_rdata : rd_data_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_ok;
        end
      end

      assign bus.rd_data  = rd_data_q;
      assign bus.rd_valid = rd_valid_q;
    end else begin : g_show
      // Head of queue is always on display; rd_en acknowledges it.
      assign bus.rd_data  = mem_rdata;
      assign bus.rd_valid = !empty;
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule : sync_fifo_ctrl

// File: tb/tb_sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_ctrl
// Drives one registered-read FIFO and one show-ahead FIFO (default geometry)
// and compares every status/data output against a queue-based model after
// each clock edge.
// -----------------------------------------------------------------------------
module tb_sync_fifo_ctrl;
  import sync_fifo_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sync_fifo_ctrl_if #(.WIDTH(8), .ADDR_W(3)) bus_r ();
  sync_fifo_ctrl_if #(.WIDTH(8), .ADDR_W(3)) bus_s ();

  sync_fifo_ctrl #(
    .WIDTH(8), .ADDR_W(3), .AF_LVL(6), .AE_LVL(2), .REG_OUT(REGISTERED)
  ) dut_r (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_r)
  );

  sync_fifo_ctrl #(
    .WIDTH(8), .ADDR_W(3), .AF_LVL(6), .AE_LVL(2), .REG_OUT(SHOW_AHEAD)
  ) dut_s (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_s)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: a plain queue per FIFO plus sticky error bits.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       ovf0, unf0, ovf1, unf1;
  logic [7:0] last_d;
  logic       last_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_r.wr_en = 1'b0; bus_r.wr_data = 8'h00; bus_r.rd_en = 1'b0; bus_r.clr_err = 1'b0;
    bus_s.wr_en = 1'b0; bus_s.wr_data = 8'h00; bus_s.rd_en = 1'b0; bus_s.clr_err = 1'b0;
  endtask

  task automatic check(input int sel);
    int n;
    if (sel == 0) begin
      n = q0.size();
      chk("r.count",     32'(bus_r.count),        32'(n));
      chk("r.empty",     32'(bus_r.empty),        32'(n == 0));
      chk("r.full",      32'(bus_r.full),         32'(n == 8));
      chk("r.afull",     32'(bus_r.almost_full),  32'(n >= 6));
      chk("r.aempty",    32'(bus_r.almost_empty), 32'(n <= 2));
      chk("r.overflow",  32'(bus_r.overflow),     32'(ovf0));
      chk("r.underflow", 32'(bus_r.underflow),    32'(unf0));
      chk("r.rd_valid",  32'(bus_r.rd_valid),     32'(last_v));
      chk("r.rd_data",   32'(bus_r.rd_data),      32'(last_d));
    end else begin
      n = q1.size();
      chk("s.count",     32'(bus_s.count),        32'(n));
      chk("s.empty",     32'(bus_s.empty),        32'(n == 0));
      chk("s.full",      32'(bus_s.full),         32'(n == 8));
      chk("s.afull",     32'(bus_s.almost_full),  32'(n >= 6));
      chk("s.aempty",    32'(bus_s.almost_empty), 32'(n <= 2));
      chk("s.overflow",  32'(bus_s.overflow),     32'(ovf1));
      chk("s.underflow", 32'(bus_s.underflow),    32'(unf1));
      chk("s.rd_valid",  32'(bus_s.rd_valid),     32'(n != 0));
      if (n != 0) chk("s.rd_data", 32'(bus_s.rd_data), 32'(q1[0]));
    end
  endtask

  // One clock of traffic on the selected FIFO; model updated from the
  // occupancy seen before the edge, then every output checked after it.
  task automatic cycle(input int sel, input bit wr, input logic [7:0] d,
                       input bit rd, input bit clr);
    bit wa, ra;
    idle_inputs();
    if (sel == 0) begin
      bus_r.wr_en = wr; bus_r.wr_data = d; bus_r.rd_en = rd; bus_r.clr_err = clr;
      wa = wr && (q0.size() < 8);
      ra = rd && (q0.size() > 0);
      last_v = ra;
      if (ra) last_d = q0.pop_front();
      if (wa) q0.push_back(d);
      ovf0 = (wr && !wa) || (ovf0 && !clr);
      unf0 = (rd && !ra) || (unf0 && !clr);
    end else begin
      bus_s.wr_en = wr; bus_s.wr_data = d; bus_s.rd_en = rd; bus_s.clr_err = clr;
      wa = wr && (q1.size() < 8);
      ra = rd && (q1.size() > 0);
      if (ra) void'(q1.pop_front());
      if (wa) q1.push_back(d);
      ovf1 = (wr && !wa) || (ovf1 && !clr);
      unf1 = (rd && !ra) || (unf1 && !clr);
    end
    @(posedge clk); #1;
    check(sel);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("rst.r.count", 32'(bus_r.count), 32'd0);
    chk("rst.r.empty", 32'(bus_r.empty), 32'd1);
    chk("rst.s.count", 32'(bus_s.count), 32'd0);
    chk("rst.s.empty", 32'(bus_s.empty), 32'd1);
    q0.delete(); q1.delete();
    ovf0 = 1'b0; unf0 = 1'b0; ovf1 = 1'b0; unf1 = 1'b0;
    last_d = 8'h00; last_v = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check(0);
    check(1);
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    do_reset();

    // Idle after reset.
    cycle(0, 0, 8'h00, 0, 0);
    cycle(1, 0, 8'h00, 0, 0);

    // Fill with 0x01..0x08, then one write too many.
    for (int i = 1; i <= 8; i++) cycle(0, 1, 8'(i), 0, 0);
    cycle(0, 1, 8'hFF, 0, 0);

    // Drain in order, then one read too many.
    for (int i = 0; i < 8; i++) cycle(0, 0, 8'h00, 1, 0);
    cycle(0, 0, 8'h00, 1, 0);
    cycle(0, 0, 8'h00, 0, 1);

    // Steady state at occupancy 4 with simultaneous push/pop across wrap.
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'($urandom), 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 1, 8'($urandom), 1, 0);

    // Full with write and read together: only the read goes through.
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'($urandom), 0, 0);
    cycle(0, 1, 8'h5A, 1, 0);
    cycle(0, 0, 8'h00, 0, 1);

    // Random traffic, write-heavy then read-heavy to reach both extremes.
    for (int i = 0; i < 300; i++) begin
      int wb;
      wb = (i < 150) ? 70 : 30;
      cycle(0, $urandom_range(0, 99) < wb, 8'($urandom),
            $urandom_range(0, 99) < (100 - wb), $urandom_range(0, 99) < 5);
    end

    // Show-ahead port: head visible without any read request.
    do_reset();
    cycle(1, 1, 8'hA5, 0, 0);
    cycle(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 200; i++) begin
      cycle(1, $urandom_range(0, 99) < 55, 8'($urandom),
            $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 5);
    end

    // Reset with data queued on both FIFOs.
    for (int i = 0; i < 3; i++) cycle(1, 1, 8'($urandom), 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'($urandom), 0, 0);
    do_reset();
    cycle(1, 0, 8'h00, 1, 0);
    cycle(0, 0, 8'h00, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_sync_fifo_ctrl
